// File: rtl/memory_stage.sv
// memory_stage -- pipeline memory stage (state updates on falling edge of I_CLOCK).
//
// Purpose: passes execute results through to writeback with one cycle of
// latency. LDB/LDW/STB/STW instead issue a single data-memory request and
// hold the pipeline (O_MEM_Stall_Signal) until the memory acks.
//
// Ports:
//   I_CLOCK, I_RESET (sync, active-high), I_LOCK (run enable)
//   I_EX_Valid + execute fields (opcode, PC, IR, dests, values, CC, enables)
//   I_MARValue / I_MDRValue : byte address / store data
//   O_DMem* / I_DMemAck / I_DMemRData : data-memory handshake; request is
//     held stable until a one-cycle ack
//   O_* writeback fields, O_MEM_Valid, O_LOCK (I_LOCK delayed one cycle)
//   O_MEM_Stall_Signal : high while a memory access is outstanding
//   O_StallCount       : saturating count of cycles spent stalled
module memory_stage #(
   parameter int          OPCODE_WIDTH  = 8,
   parameter int          PC_WIDTH      = 16,
   parameter int          IR_WIDTH      = 16,
   parameter int          VREG_ID_WIDTH = 6,
   parameter int          REG_WIDTH     = 16,
   parameter int          VREG_WIDTH    = 64,
   parameter logic [7:0]  OP_LDB        = 8'h40,
   parameter logic [7:0]  OP_LDW        = 8'h41,
   parameter logic [7:0]  OP_STB        = 8'h42,
   parameter logic [7:0]  OP_STW        = 8'h43
) (
   input  logic                     I_CLOCK,
   input  logic                     I_RESET,
   input  logic                     I_LOCK,
   input  logic                     I_EX_Valid,
   input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
   input  logic [PC_WIDTH-1:0]      I_PC,
   input  logic [IR_WIDTH-1:0]      I_IR,
   input  logic [3:0]               I_DestRegIdx,
   input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
   input  logic [REG_WIDTH-1:0]     I_DestValue,
   input  logic [VREG_WIDTH-1:0]    I_VecDestValue,
   input  logic [2:0]               I_CCValue,
   input  logic                     I_RegWEn,
   input  logic                     I_VRegWEn,
   input  logic                     I_CCWEn,
   input  logic [REG_WIDTH-1:0]     I_MARValue,
   input  logic [REG_WIDTH-1:0]     I_MDRValue,
   output logic                     O_DMemReq,
   output logic                     O_DMemWE,
   output logic [REG_WIDTH-1:0]     O_DMemAddr,
   output logic [REG_WIDTH-1:0]     O_DMemWData,
   output logic [1:0]               O_DMemByteEn,
   input  logic                     I_DMemAck,
   input  logic [REG_WIDTH-1:0]     I_DMemRData,
   output logic                     O_LOCK,
   output logic [PC_WIDTH-1:0]      O_PC,
   output logic [IR_WIDTH-1:0]      O_IR,
   output logic [OPCODE_WIDTH-1:0]  O_Opcode,
   output logic [3:0]               O_DestRegIdx,
   output logic [VREG_ID_WIDTH-1:0] O_DestVRegIdx,
   output logic [REG_WIDTH-1:0]     O_DestValue,
   output logic [VREG_WIDTH-1:0]    O_VecDestValue,
   output logic [2:0]               O_CCValue,
   output logic                     O_RegWEn,
   output logic                     O_VRegWEn,
   output logic                     O_CCWEn,
   output logic                     O_MEM_Valid,
   output logic                     O_MEM_Stall_Signal,
   output logic [15:0]              O_StallCount
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic                     lock_q, lock_d;
   logic                     valid_q, valid_d;
   logic [PC_WIDTH-1:0]      pc_q, pc_d;
   logic [IR_WIDTH-1:0]      ir_q, ir_d;
   logic [OPCODE_WIDTH-1:0]  op_q, op_d;
   logic [3:0]               rdst_q, rdst_d;
   logic [VREG_ID_WIDTH-1:0] vdst_q, vdst_d;
   logic [REG_WIDTH-1:0]     dval_q, dval_d;
   logic [VREG_WIDTH-1:0]    vval_q, vval_d;
   logic [2:0]               cc_q, cc_d;
   logic                     rwen_q, rwen_d;
   logic                     vwen_q, vwen_d;
   logic                     ccwen_q, ccwen_d;
   // Write enables of the instruction parked in ACCESS; only released to the
   // O_*WEn outputs on completion so nothing downstream sees them early.
   logic                     lrwen_q, lrwen_d;
   logic                     lvwen_q, lvwen_d;
   logic                     lccwen_q, lccwen_d;
   logic                     req_q, req_d;
   logic                     we_q, we_d;
   logic [REG_WIDTH-1:0]     addr_q, addr_d;
   logic [REG_WIDTH-1:0]     wdata_q, wdata_d;
   logic [1:0]               be_q, be_d;
   logic [15:0]              scnt_q, scnt_d;

   logic in_byte, in_word, in_store, in_mem;
   logic cur_ldb, cur_ldw;
   logic [7:0] rbyte;

   // Opcode decode is done on the OPCODE_WIDTH-wide field; constants are 8b.
   assign in_byte  = (I_Opcode == OPCODE_WIDTH'(OP_LDB)) || (I_Opcode == OPCODE_WIDTH'(OP_STB));
   assign in_word  = (I_Opcode == OPCODE_WIDTH'(OP_LDW)) || (I_Opcode == OPCODE_WIDTH'(OP_STW));
   assign in_store = (I_Opcode == OPCODE_WIDTH'(OP_STB)) || (I_Opcode == OPCODE_WIDTH'(OP_STW));
   assign in_mem   = in_byte || in_word;
   assign cur_ldb  = (op_q == OPCODE_WIDTH'(OP_LDB));
   assign cur_ldw  = (op_q == OPCODE_WIDTH'(OP_LDW));
   // For byte loads the byte-enable already encodes which half MAR[0] picked.
   assign rbyte    = be_q[1] ? I_DMemRData[15:8] : I_DMemRData[7:0];

   always_comb begin
      state_d  = state_q;
      lock_d   = I_LOCK;
      valid_d  = 1'b0;
      pc_d     = pc_q;
      ir_d     = ir_q;
      op_d     = op_q;
      rdst_d   = rdst_q;
      vdst_d   = vdst_q;
      dval_d   = dval_q;
      vval_d   = vval_q;
      cc_d     = cc_q;
      rwen_d   = 1'b0;
      vwen_d   = 1'b0;
      ccwen_d  = 1'b0;
      lrwen_d  = lrwen_q;
      lvwen_d  = lvwen_q;
      lccwen_d = lccwen_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      scnt_d   = scnt_q;

      case (state_q)
         IDLE: begin
            // I_DMemAck is deliberately not looked at here.
            if (I_LOCK && I_EX_Valid) begin
               pc_d   = I_PC;
               ir_d   = I_IR;
               op_d   = I_Opcode;
               rdst_d = I_DestRegIdx;
               vdst_d = I_DestVRegIdx;
               dval_d = I_DestValue;
               vval_d = I_VecDestValue;
               cc_d   = I_CCValue;
               if (in_mem) begin
                  lrwen_d  = I_RegWEn;
                  lvwen_d  = I_VRegWEn;
                  lccwen_d = I_CCWEn;
                  req_d    = 1'b1;
                  we_d     = in_store;
                  addr_d   = {I_MARValue[REG_WIDTH-1:1], 1'b0};
                  wdata_d  = in_byte ? {(REG_WIDTH/8){I_MDRValue[7:0]}} : I_MDRValue;
                  be_d     = in_word ? 2'b11 : (I_MARValue[0] ? 2'b10 : 2'b01);
                  state_d  = ACCESS;
               end else begin
                  valid_d = 1'b1;
                  rwen_d  = I_RegWEn;
                  vwen_d  = I_VRegWEn;
                  ccwen_d = I_CCWEn;
               end
            end
         end
         ACCESS: begin
            if (scnt_q != 16'hFFFF) scnt_d = scnt_q + 16'd1;
            // Completion: nothing new is captured on this edge; the execute
            // stage still holds its next instruction until stall drops.
            if (I_DMemAck) begin
               req_d   = 1'b0;
               state_d = IDLE;
               if (cur_ldw)      dval_d = I_DMemRData;
               else if (cur_ldb) dval_d = {{(REG_WIDTH-8){rbyte[7]}}, rbyte};
               if (I_LOCK) begin
                  valid_d = 1'b1;
                  rwen_d  = lrwen_q && !we_q;  // stores never write a register
                  vwen_d  = lvwen_q;
                  ccwen_d = lccwen_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(negedge I_CLOCK) begin
      if (I_RESET) begin
         state_q  <= IDLE;
         lock_q   <= 1'b0;
         valid_q  <= 1'b0;
         pc_q     <= '0;
         ir_q     <= '0;
         op_q     <= '0;
         rdst_q   <= '0;
         vdst_q   <= '0;
         dval_q   <= '0;
         vval_q   <= '0;
         cc_q     <= '0;
         rwen_q   <= 1'b0;
         vwen_q   <= 1'b0;
         ccwen_q  <= 1'b0;
         lrwen_q  <= 1'b0;
         lvwen_q  <= 1'b0;
         lccwen_q <= 1'b0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         scnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         lock_q   <= lock_d;
         valid_q  <= valid_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         op_q     <= op_d;
         rdst_q   <= rdst_d;
         vdst_q   <= vdst_d;
         dval_q   <= dval_d;
         vval_q   <= vval_d;
         cc_q     <= cc_d;
         rwen_q   <= rwen_d;
         vwen_q   <= vwen_d;
         ccwen_q  <= ccwen_d;
         lrwen_q  <= lrwen_d;
         lvwen_q  <= lvwen_d;
         lccwen_q <= lccwen_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         scnt_q   <= scnt_d;
      end
   end

   assign O_LOCK             = lock_q;
   assign O_MEM_Valid        = valid_q;
   assign O_PC               = pc_q;
   assign O_IR               = ir_q;
   assign O_Opcode           = op_q;
   assign O_DestRegIdx       = rdst_q;
   assign O_DestVRegIdx      = vdst_q;
   assign O_DestValue        = dval_q;
   assign O_VecDestValue     = vval_q;
   assign O_CCValue          = cc_q;
   assign O_RegWEn           = rwen_q;
   assign O_VRegWEn          = vwen_q;
   assign O_CCWEn            = ccwen_q;
   assign O_DMemReq          = req_q;
   assign O_DMemWE           = we_q;
   assign O_DMemAddr         = addr_q;
   assign O_DMemWData        = wdata_q;
   assign O_DMemByteEn       = be_q;
   assign O_MEM_Stall_Signal = (state_q == ACCESS);
   assign O_StallCount       = scnt_q;

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have one clock, I_CLOCK; all state updates on the falling edge of I_CLOCK, matching the pipeline.
REQ-002 SHALL have reset I_RESET, synchronous and active-high.
REQ-003 SHALL have ports (widths from global_def.h):
- I_CLOCK in 1: pipeline clock.
- I_RESET in 1: synchronous active-high reset.
- I_LOCK in 1: pipeline run enable.
- I_EX_Valid in 1: execute-stage output valid.
- I_Opcode in OPCODE_WIDTH: execute opcode.
- I_PC in PC_WIDTH: instruction PC.
- I_IR in IR_WIDTH: instruction word.
- I_DestRegIdx in 4: scalar destination.
- I_DestVRegIdx in VREG_ID_WIDTH: vector destination.
- I_DestValue in REG_WIDTH: ALU result.
- I_VecDestValue in VREG_WIDTH: vector result.
- I_CCValue in 3: condition codes.
- I_RegWEn, I_VRegWEn, I_CCWEn in 1 each: write enables.
- I_MARValue in REG_WIDTH: byte address.
- I_MDRValue in REG_WIDTH: store data.
- O_DMemReq out 1: memory request.
- O_DMemWE out 1: 1 = write.
- O_DMemAddr out REG_WIDTH: word address (bit 0 = 0).
- O_DMemWData out REG_WIDTH: write data.
- O_DMemByteEn out 2: byte lanes [1]=high, [0]=low.
- I_DMemAck in 1: one-cycle completion pulse.
- I_DMemRData in REG_WIDTH: read data, valid with ack.
- O_LOCK, O_PC, O_IR, O_Opcode, O_DestRegIdx, O_DestVRegIdx, O_DestValue, O_VecDestValue, O_CCValue, O_RegWEn, O_VRegWEn, O_CCWEn out (input widths): registered writeback outputs.
- O_MEM_Valid out 1: writeback outputs valid.
- O_MEM_Stall_Signal out 1: combinational, hold execute outputs.
- O_StallCount out 16: cycles spent stalled.

Function
REQ-004 SHALL implement FSM states IDLE and ACCESS.
REQ-005 In IDLE, with I_LOCK=1 and I_EX_Valid=1 and a non-memory opcode: SHALL register all pass-through fields with O_MEM_Valid=1 (1-cycle latency) and stay in IDLE.
REQ-006 In IDLE, with I_LOCK=1 and I_EX_Valid=1 and opcode LDB/LDW/STB/STW: SHALL latch all fields, drive O_DMemReq=1, and go to ACCESS; O_MEM_Valid=0 for that cycle.
REQ-007 LDW/STW SHALL drive O_DMemByteEn=2'b11; MAR bit 0 is ignored.
REQ-008 LDB/STB SHALL use MAR[0]: 1 -> 2'b10, 0 -> 2'b01.
REQ-009 O_DMemAddr SHALL equal {MAR[15:1],1'b0}.
REQ-010 O_DMemWE SHALL be 1 for STB/STW and 0 for LDB/LDW.
REQ-011 STB SHALL drive {MDR[7:0],MDR[7:0]}; STW SHALL drive MDR.
REQ-012 O_DMemReq, O_DMemAddr, O_DMemWData, O_DMemWE and O_DMemByteEn SHALL be held stable throughout ACCESS.
REQ-013 O_MEM_Stall_Signal SHALL equal (state==ACCESS).
REQ-014 In ACCESS, on an edge sampling I_DMemAck=1: SHALL drop O_DMemReq, set O_MEM_Valid=1, and return to IDLE; the stage SHALL NOT capture a new input on that edge.
REQ-015 LDW SHALL write I_DMemRData to O_DestValue.
REQ-016 LDB SHALL write the selected byte, sign-extended to REG_WIDTH, to O_DestValue.
REQ-017 Stores SHALL force O_RegWEn=0 on completion.
REQ-018 I_DMemAck SHALL be ignored in IDLE.
REQ-019 ACCESS has no timeout.
REQ-020 I_LOCK=0 SHALL block new captures and force O_MEM_Valid=0 and all write enables to 0; an ACCESS already in progress SHALL still complete.
REQ-021 O_StallCount SHALL increment each cycle in ACCESS and saturate at 16'hFFFF.
REQ-022 O_LOCK SHALL follow I_LOCK one cycle later.

Reset
REQ-023 I_RESET SHALL take priority over all other inputs.
REQ-024 On reset: state=IDLE, O_DMemReq=0, O_MEM_Valid=0, O_LOCK=0, all write enables 0, all data outputs 0, O_StallCount=0.
REQ-025 Reset during ACCESS SHALL abandon the request; O_DMemReq is 0 at the following edge and any later ack is ignored.

Verification
REQ-026 ADD result 16'h0042 to R3 -> next edge O_MEM_Valid=1, O_DestValue=16'h0042, O_RegWEn=1, stall never asserted.
REQ-027 LDB, MAR=16'h1001, ack after 3 cycles, RData=16'h8F12 -> Addr=16'h1000, ByteEn=2'b10, O_DestValue=16'hFF8F, O_StallCount=3.
REQ-028 STW, MAR=16'h2004, MDR=16'hBEEF -> WE=1, ByteEn=2'b11, WData=16'hBEEF, O_RegWEn=0 on completion.
REQ-029 STB, MAR=16'h0000, MDR=16'h12AB -> WData=16'hABAB, ByteEn=2'b01.
REQ-030 LDW followed by ADD held by execute, ack after 5 cycles -> stall high for 5 cycles; ADD valid exactly one cycle after the LDW result, no duplicate and no loss.
REQ-031 Reset asserted during ACCESS, then ack pulsed -> O_DMemReq=0 after the reset edge, O_MEM_Valid stays 0, state IDLE.
